instr_fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle MIPS core, sitting directly upstream of the control unit and datapath. Holds the PC and fetches one word at a time from instruction memory over a req/ack handshake. Presents the fetched instruction (with opcode/funct slices) until the datapath retires it, then computes the next PC from branch/jump/zero. Also keeps a retired-instruction counter.

---
 rtl/instr_fetch_unit_if.sv | 22 ++
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch port: a one-word request/acknowledge handshake.
// The fetch unit is the master; the instruction memory is the slave.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the single-cycle MIPS core.
// Holds the PC and fetches one word per instruction over the imem handshake.
// It presents the held instruction to decode until the datapath retires it.
// It then steps the PC using jump (highest priority), taken branch or sequential flow.
// It also counts retired instructions.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                instr,
    output logic                       instr_valid,
    output logic [5:0]                 opcode,
    output logic [5:0]                 funct,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus4,
    input  logic                       advance,
    input  logic                       branch,
    input  logic                       zero,
    input  logic                       jump,
    output logic [31:0]                retired_count
);

    // The reset PC is forced to a word boundary.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;
    logic        imem_req_s;
    logic        instr_valid_s;

    // Next PC from the held instruction.
    // Jump wins over branch; a branch is taken only when zero is set.
    // All arithmetic wraps modulo 2^32.
    function automatic logic [31:0] calc_next_pc(
        input logic [31:0] pc_p4,
        input logic [31:0] ins,
        input logic        br,
        input logic        zf,
        input logic        jmp
    );
        logic [31:0] offset;
        offset = {{14{ins[15]}}, ins[15:0], 2'b00};
        if (jmp) begin
            calc_next_pc = {pc_p4[31:28], ins[25:0], 2'b00};
        end else if (br && zf) begin
            calc_next_pc = pc_p4 + offset;
        end else begin
            calc_next_pc = pc_p4;
        end
    endfunction

    assign pc_plus4_s = pc_q + 32'd4;
    assign next_pc_s  = calc_next_pc(pc_plus4_s, instr_q, branch, zero, jump);

    // Next-state, datapath register updates and state-decoded handshake outputs.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        retired_d     = retired_q;
        imem_req_s    = 1'b0;
        instr_valid_s = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req_s = 1'b1;
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = HOLD;
                end else begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                instr_valid_s = 1'b1;
                if (advance) begin
                    pc_d      = next_pc_s;
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC_ALIGNED;
            instr_q   <= 32'h0000_0000;
            retired_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign imem.imem_req  = imem_req_s;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_s;
    assign opcode         = instr_q[31:26];
    assign funct          = instr_q[5:0];
    assign pc             = pc_q;
    assign pc_plus4       = pc_plus4_s;
    assign retired_count  = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
// Instance A (RESET_PC 0x3000) runs reset checks, a table of instruction retires and wait-state sequences.
// Instance B (RESET_PC 0xFFFFFFFC) covers PC wrap and reset in the middle of a fetch.
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n_a, rst_n_b;

    logic [31:0] instr_a, pc_a, pc_plus4_a, retired_a;
    logic        valid_a;
    logic [5:0]  opcode_a, funct_a;
    logic        advance_a, branch_a, zero_a, jump_a;

    logic [31:0] instr_b, pc_b, pc_plus4_b, retired_b;
    logic        valid_b;
    logic [5:0]  opcode_b, funct_b;
    logic        advance_b, branch_b, zero_b, jump_b;

    instr_fetch_unit_if if_a ();
    instr_fetch_unit_if if_b ();

    instr_fetch_unit #(.RESET_PC(32'h0000_3000)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .imem(if_a.master),
        .instr(instr_a), .instr_valid(valid_a), .opcode(opcode_a), .funct(funct_a),
        .pc(pc_a), .pc_plus4(pc_plus4_a), .advance(advance_a), .branch(branch_a),
        .zero(zero_a), .jump(jump_a), .retired_count(retired_a)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .imem(if_b.master),
        .instr(instr_b), .instr_valid(valid_b), .opcode(opcode_b), .funct(funct_b),
        .pc(pc_b), .pc_plus4(pc_plus4_b), .advance(advance_b), .branch(branch_b),
        .zero(zero_b), .jump(jump_b), .retired_count(retired_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        branch;
        logic        zero;
        logic        jump;
        logic [5:0]  exp_opcode;
        logic [5:0]  exp_funct;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
        logic [31:0] exp_retired;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table of instructions retired back to back on instance A.
        vecs[0] = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 6'h08, 6'h05, 32'h0000_3000, 32'h0000_3004, 32'd1};
        vecs[1] = '{32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 6'h04, 6'h3F, 32'h0000_3004, 32'h0000_3004, 32'd2};
        vecs[2] = '{32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 6'h04, 6'h3F, 32'h0000_3004, 32'h0000_3008, 32'd3};
        vecs[3] = '{32'h0800_0C00, 1'b1, 1'b1, 1'b1, 6'h02, 6'h00, 32'h0000_3008, 32'h0000_3000, 32'd4};
        vecs[4] = '{32'h1000_0004, 1'b1, 1'b1, 1'b0, 6'h04, 6'h04, 32'h0000_3000, 32'h0000_3014, 32'd5};
        vecs[5] = '{32'h1000_0010, 1'b0, 1'b1, 1'b0, 6'h04, 6'h10, 32'h0000_3014, 32'h0000_3018, 32'd6};
        vecs[6] = '{32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1, 6'h02, 6'h3F, 32'h0000_3018, 32'h0FFF_FFFC, 32'd7};
        vecs[7] = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 6'h00, 6'h20, 32'h0FFF_FFFC, 32'h1000_0000, 32'd8};
        vecs[8] = '{32'h0800_0C00, 1'b0, 1'b0, 1'b1, 6'h02, 6'h00, 32'h1000_0000, 32'h1000_3000, 32'd9};
        vecs[9] = '{32'h1000_8000, 1'b1, 1'b1, 1'b0, 6'h04, 6'h00, 32'h1000_3000, 32'h0FFE_3004, 32'd10};

        rst_n_a = 1'b0; rst_n_b = 1'b0;
        if_a.imem_ack = 1'b1; if_a.imem_rdata = 32'h1234_5678;
        advance_a = 1'b0; branch_a = 1'b0; zero_a = 1'b0; jump_a = 1'b0;
        if_b.imem_ack = 1'b0; if_b.imem_rdata = 32'h0000_0000;
        advance_b = 1'b0; branch_b = 1'b0; zero_b = 1'b0; jump_b = 1'b0;

        // Reset held with ack high: no request, nothing valid.
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_req", {31'd0, if_a.imem_req}, 32'd0);
            chk("rst_valid", {31'd0, valid_a}, 32'd0);
            step();
        end
        chk("rst_addr", if_a.imem_addr, 32'h0000_3000);
        chk("rst_pc4", pc_plus4_a, 32'h0000_3004);
        chk("rst_instr", instr_a, 32'h0000_0000);
        chk("rst_retired", retired_a, 32'd0);

        // Release: cycle 1 idle, cycle 2 requests at the reset PC.
        rst_n_a = 1'b1;
        if_a.imem_ack = 1'b0;
        #1;
        chk("cyc1_req", {31'd0, if_a.imem_req}, 32'd0);
        step();
        chk("cyc2_req", {31'd0, if_a.imem_req}, 32'd1);
        chk("cyc2_addr", if_a.imem_addr, vecs[0].exp_pc);

        // Table: zero-wait fetch, then retire with the vector's branch/zero/jump.
        for (int i = 0; i < 10; i++) begin
            if_a.imem_ack = 1'b1;
            if_a.imem_rdata = vecs[i].rdata;
            step();
            if_a.imem_ack = 1'b0;
            chk("v_valid", {31'd0, valid_a}, 32'd1);
            chk("v_req_hold", {31'd0, if_a.imem_req}, 32'd0);
            chk("v_instr", instr_a, vecs[i].rdata);
            chk("v_opcode", {26'd0, opcode_a}, {26'd0, vecs[i].exp_opcode});
            chk("v_funct", {26'd0, funct_a}, {26'd0, vecs[i].exp_funct});
            chk("v_pc", pc_a, vecs[i].exp_pc);
            chk("v_pc4", pc_plus4_a, vecs[i].exp_pc + 32'd4);
            advance_a = 1'b1;
            branch_a = vecs[i].branch;
            zero_a = vecs[i].zero;
            jump_a = vecs[i].jump;
            step();
            advance_a = 1'b0; branch_a = 1'b0; zero_a = 1'b0; jump_a = 1'b0;
            chk("v_next_req", {31'd0, if_a.imem_req}, 32'd1);
            chk("v_next_addr", if_a.imem_addr, vecs[i].exp_next);
            chk("v_next_valid", {31'd0, valid_a}, 32'd0);
            chk("v_retired", retired_a, vecs[i].exp_retired);
        end

        // Wait states: ack delayed 3 cycles; advance/jump asserted in FETCH are ignored.
        advance_a = 1'b1; jump_a = 1'b1; branch_a = 1'b1; zero_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_req", {31'd0, if_a.imem_req}, 32'd1);
            chk("ws_addr", if_a.imem_addr, 32'h0FFE_3004);
            chk("ws_valid", {31'd0, valid_a}, 32'd0);
            chk("ws_retired", retired_a, 32'd10);
        end
        advance_a = 1'b0; jump_a = 1'b0; branch_a = 1'b0; zero_a = 1'b0;
        if_a.imem_ack = 1'b1; if_a.imem_rdata = 32'h2009_0007;
        step();
        if_a.imem_ack = 1'b0;
        chk("ws_got", instr_a, 32'h2009_0007);

        // HOLD without advance for 2 cycles; a stray ack must not replace instr.
        for (int i = 0; i < 2; i++) begin
            if_a.imem_ack = (i == 0) ? 1'b1 : 1'b0;
            if_a.imem_rdata = 32'hDEAD_BEEF;
            step();
            chk("hold_instr", instr_a, 32'h2009_0007);
            chk("hold_req", {31'd0, if_a.imem_req}, 32'd0);
            chk("hold_valid", {31'd0, valid_a}, 32'd1);
            chk("hold_pc", pc_a, 32'h0FFE_3004);
        end
        if_a.imem_ack = 1'b0;
        advance_a = 1'b1;
        step();
        advance_a = 1'b0;
        chk("ws_next_addr", if_a.imem_addr, 32'h0FFE_3008);
        chk("ws_retired2", retired_a, 32'd11);

        // Instance B: PC wraps from 0xFFFFFFFC to 0.
        rst_n_b = 1'b1;
        #1;
        chk("b_cyc1_req", {31'd0, if_b.imem_req}, 32'd0);
        chk("b_rst_pc4", pc_plus4_b, 32'h0000_0000);
        step();
        chk("b_addr", if_b.imem_addr, 32'hFFFF_FFFC);
        if_b.imem_ack = 1'b1; if_b.imem_rdata = 32'h0000_0000;
        step();
        if_b.imem_ack = 1'b0;
        chk("b_pc", pc_b, 32'hFFFF_FFFC);
        chk("b_valid", {31'd0, valid_b}, 32'd1);
        advance_b = 1'b1;
        step();
        advance_b = 1'b0;
        chk("b_wrap_addr", if_b.imem_addr, 32'h0000_0000);
        chk("b_wrap_req", {31'd0, if_b.imem_req}, 32'd1);
        chk("b_retired", retired_b, 32'd1);

        // Reset asserted mid-FETCH with ack pending: request drops at once.
        if_b.imem_ack = 1'b1; if_b.imem_rdata = 32'h1111_2222;
        rst_n_b = 1'b0;
        #1;
        chk("b_async_req", {31'd0, if_b.imem_req}, 32'd0);
        chk("b_async_addr", if_b.imem_addr, 32'hFFFF_FFFC);
        chk("b_async_retired", retired_b, 32'd0);
        step();
        chk("b_rst_instr", instr_b, 32'h0000_0000);
        chk("b_rst_valid", {31'd0, valid_b}, 32'd0);
        rst_n_b = 1'b1;
        if_b.imem_ack = 1'b0;
        step();
        chk("b_restart_req", {31'd0, if_b.imem_req}, 32'd1);
        chk("b_restart_addr", if_b.imem_addr, 32'hFFFF_FFFC);
        chk("b_restart_retired", retired_b, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
